seq_detect_controller: RTL and testbench

Run-controller around a programmable serial bit-pattern matcher.
- Software loads a pattern (1..MAX_LEN bits) and a frame length, then pulses start.
- The block arms the matcher, clears its history, and scans exactly cfg_frame_len valid input bits. Overlapping matches are allowed.
- Each match produces a one-cycle detected pulse and increments match_count. At frame end the block reports done.
- Replaces the fixed-pattern detect FSMs wherever the pattern must change at run time.

---
 rtl/seq_detect_pkg.sv | 24 ++
 rtl/seq_detect_controller_matcher.sv | 45 ++++
 rtl/seq_detect_controller.sv | 131 +++++++++++++
 tb/tb_seq_detect_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the run-controlled serial pattern detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_FRAME_W = 8;

  // Mask of the low len bits; callers truncate to their window width.
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) begin
      len_mask = '1;
    end else begin
      len_mask = (32'd1 << len) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/seq_detect_controller_matcher.sv
// Serial history window with a fill counter; flags a match on the bit being shifted in.
module pattern_window_matcher
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_next;
  logic [LEN_W-1:0]   w_eff_len;

  assign w_eff_len   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign w_hist_next = (r_hist << 1) | MAX_LEN'(bit_in);
  assign w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_mask      = MAX_LEN'(len_mask(32'(w_eff_len)));

  // Compare against the window as it will look after this bit lands.
  assign match = shift && (w_eff_len != '0)
              && (((w_hist_next ^ pattern) & w_mask) == '0)
              && (w_fill_next >= w_eff_len);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_hist <= w_hist_next;
      r_fill <= w_fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_controller.sv
// Run controller: latches config on start, scans cfg_frame_len accepted bits, counts matches.
// Handshake: a bit is consumed on any RUN-state edge where a_valid=1; there is no backpressure.
module seq_detect_controller
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int CNT_W   = DEF_CNT_W,
  parameter  int FRAME_W = DEF_FRAME_W,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [FRAME_W-1:0] cfg_frame_len,
  input  logic               start,
  input  logic               a_valid,
  input  logic               a,
  output logic               busy,
  output logic               done,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow,
  output logic [1:0]         o_dbg_state
);

  state_t             r_state;
  state_t             w_state_next;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [FRAME_W-1:0] r_frame_len;
  logic [FRAME_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0]   r_match_count;
  logic               r_overflow;
  logic               r_detected;
  logic               w_clear;
  logic               w_shift;
  logic               w_match;
  logic               w_last_bit;

  assign w_clear    = (r_state == ARM);
  assign w_shift    = (r_state == RUN) && a_valid;
  assign w_last_bit = (r_bit_cnt + FRAME_W'(1)) == r_frame_len;

  pattern_window_matcher #(
    .MAX_LEN (MAX_LEN)
  ) u_matcher (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .shift   (w_shift),
    .bit_in  (a),
    .pattern (r_pattern),
    .len     (r_len),
    .match   (w_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = ARM;
      ARM: begin
        busy         = 1'b1;
        w_state_next = (r_frame_len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_shift && w_last_bit) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern     <= '0;
      r_len         <= '0;
      r_frame_len   <= '0;
      r_bit_cnt     <= '0;
      r_match_count <= '0;
      r_overflow    <= 1'b0;
      r_detected    <= 1'b0;
    end else begin
      r_detected <= 1'b0;
      if (r_state == IDLE && start) begin
        r_pattern   <= cfg_pattern;
        r_len       <= cfg_len;
        r_frame_len <= cfg_frame_len;
      end
      case (r_state)
        ARM: begin
          r_bit_cnt     <= '0;
          r_match_count <= '0;
          r_overflow    <= 1'b0;
        end
        RUN: begin
          if (w_shift) begin
            r_bit_cnt  <= r_bit_cnt + FRAME_W'(1);
            r_detected <= w_match;
            // Saturate: a match arriving at all-ones only raises overflow.
            if (w_match) begin
              if (&r_match_count) r_overflow <= 1'b1;
              else                r_match_count <= r_match_count + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign detected    = r_detected;
  assign match_count = r_match_count;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_detect_controller.sv
// Bench for seq_detect_controller: a default instance and a 3-bit-counter instance share stimulus.
module tb_seq_detect_controller;
  import seq_detect_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_frame_len;
  logic       start, a_valid, a;
  logic       busy, done, detected, overflow;
  logic [7:0] match_count;
  logic [1:0] dbg_state;
  logic       s_busy, s_done, s_detected, s_overflow;
  logic [2:0] s_match_count;
  logic [1:0] s_dbg_state;

  int checks = 0;
  int failures = 0;
  logic stim_bits[256];
  int last_hits = 0;

  logic [18:0] w_obs;
  assign w_obs = {busy, done, detected, match_count, overflow,
                  s_busy, s_done, s_detected, s_match_count, s_overflow};

  always #5 clk = ~clk;

  seq_detect_controller u_dut (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_frame_len(cfg_frame_len), .start(start), .a_valid(a_valid), .a(a),
    .busy(busy), .done(done), .detected(detected), .match_count(match_count),
    .overflow(overflow), .o_dbg_state(dbg_state)
  );

  seq_detect_controller #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_frame_len(cfg_frame_len), .start(start), .a_valid(a_valid), .a(a),
    .busy(s_busy), .done(s_done), .detected(s_detected), .match_count(s_match_count),
    .overflow(s_overflow), .o_dbg_state(s_dbg_state)
  );

  // Expected observation for both instances given the number of matches seen so far.
  function automatic logic [18:0] exp_vec(input logic b, input logic d, input logic det, input int hits);
    logic [7:0] c8;
    logic [2:0] c3;
    c8 = (hits > 255) ? 8'hFF : 8'(hits);
    c3 = (hits > 7) ? 3'd7 : 3'(hits);
    return {b, d, det, c8, (hits > 255), b, d, det, c3, (hits > 7)};
  endfunction

  // Reference: does the window ending at accepted bit k (1-based) equal the pattern?
  function automatic bit hit_at(input logic [7:0] pat, input logic [3:0] len, input int k);
    int eff;
    eff = (len > 4'd8) ? 8 : int'(len);
    if (eff == 0 || k < eff) return 1'b0;
    for (int j = 0; j < eff; j++) begin
      if (stim_bits[k-eff+j] !== pat[eff-1-j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One complete run starting at a negedge. valid_pct<0 means alternate invalid/valid.
  task automatic run_frame(input string name, input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] flen, input int valid_pct, input bit disturb,
                           input int abort_after, output int hits, output int n_cyc);
    int k;
    int cyc;
    int budget;
    bit v;
    logic exp_det;
    logic [18:0] ev;
    hits = 0;
    exp_det = 1'b0;
    k = 0;
    cyc = 0;
    cfg_pattern = pat; cfg_len = len; cfg_frame_len = flen;
    start = 1'b1; a_valid = 1'b0; a = 1'b0;
    @(negedge clk);
    start = 1'b0;
    a_valid = 1'($urandom_range(0, 1));
    a = 1'($urandom_range(0, 1));
    ev = exp_vec(1'b1, 1'b0, 1'b0, last_hits);
    checks++;
    if (w_obs !== ev) begin
      failures++;
      $display("FAIL %s/arm obs=%b exp=%b", name, w_obs, ev);
    end
    budget = int'(flen) * 4 + 20;
    while (k < int'(flen) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      ev = exp_vec(1'b1, 1'b0, exp_det, hits);
      checks++;
      if (w_obs !== ev) begin
        failures++;
        $display("FAIL %s/run bit=%0d obs=%b exp=%b", name, k, w_obs, ev);
      end
      if (abort_after >= 0 && k == abort_after) begin
        rst = 1'b1; a_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ev = exp_vec(1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (w_obs !== ev) begin
          failures++;
          $display("FAIL %s/after_rst obs=%b exp=%b", name, w_obs, ev);
        end
        @(negedge clk);
        checks++;
        if (w_obs !== ev) begin
          failures++;
          $display("FAIL %s/no_done_after_rst obs=%b exp=%b", name, w_obs, ev);
        end
        last_hits = 0;
        hits = 0;
        n_cyc = cyc;
        return;
      end
      if (valid_pct < 0) v = (cyc % 2 == 0);
      else               v = ($urandom_range(1, 100) <= valid_pct);
      if (v) begin
        a_valid = 1'b1;
        a = stim_bits[k];
        k++;
        exp_det = hit_at(pat, len, k);
        hits += int'(exp_det);
      end else begin
        a_valid = 1'b0;
        a = 1'($urandom_range(0, 1));
        exp_det = 1'b0;
      end
      if (disturb) begin
        cfg_pattern = 8'($urandom);
        cfg_len = 4'($urandom);
        cfg_frame_len = 8'($urandom);
        start = 1'($urandom_range(0, 1));
      end
    end
    n_cyc = cyc;
    if (k < int'(flen)) begin
      checks++;
      failures++;
      $display("FAIL %s/timeout accepted=%0d frame=%0d", name, k, flen);
    end
    @(negedge clk);
    a_valid = 1'($urandom_range(0, 1));
    start = disturb;
    ev = exp_vec(1'b0, 1'b1, exp_det, hits);
    checks++;
    if (w_obs !== ev) begin
      failures++;
      $display("FAIL %s/done obs=%b exp=%b", name, w_obs, ev);
    end
    @(negedge clk);
    start = 1'b0;
    a_valid = 1'b0;
    ev = exp_vec(1'b0, 1'b0, 1'b0, hits);
    checks++;
    if (w_obs !== ev) begin
      failures++;
      $display("FAIL %s/idle_after obs=%b exp=%b", name, w_obs, ev);
    end
    last_hits = hits;
  endtask

  task automatic load_bits(input int n, input logic [255:0] first_is_msb);
    for (int i = 0; i < n; i++) stim_bits[i] = first_is_msb[n-1-i];
  endtask

  task automatic test_reset();
    logic [18:0] ev;
    rst = 1'b1; start = 1'b1; a_valid = 1'b1; a = 1'b1;
    cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_frame_len = 8'd4;
    ev = exp_vec(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (w_obs !== ev || dbg_state !== IDLE || s_dbg_state !== IDLE) begin
        failures++;
        $display("FAIL reset obs=%b exp=%b state=%0d/%0d", w_obs, ev, dbg_state, s_dbg_state);
      end
    end
    rst = 1'b0; start = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (w_obs !== ev) begin
      failures++;
      $display("FAIL reset_release obs=%b exp=%b", w_obs, ev);
    end
    last_hits = 0;
  endtask

  task automatic test_pattern_0011();
    int h, n;
    load_bits(12, 256'b110011001100);
    run_frame("t1", 8'b0011_0011, 4'd6, 8'd12, 100, 1'b0, -1, h, n);
    checks++;
    if (match_count !== 8'd2 || busy !== 1'b0 || n != 12) begin
      failures++;
      $display("FAIL t1_total count=%0d busy=%b cycles=%0d want 2/0/12", match_count, busy, n);
    end
  endtask

  task automatic test_pattern_1010();
    int h, n;
    load_bits(7, 256'b1010101);
    run_frame("t2", 8'b0000_1010, 4'd4, 8'd7, 100, 1'b0, -1, h, n);
    checks++;
    if (match_count !== 8'd2 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL t2_total count=%0d ovf=%b want 2/0", match_count, overflow);
    end
  endtask

  task automatic test_gapped_valid();
    int h, n;
    load_bits(12, 256'b110011001100);
    run_frame("t3", 8'b0011_0011, 4'd6, 8'd12, -1, 1'b0, -1, h, n);
    checks++;
    if (match_count !== 8'd2 || n != 24) begin
      failures++;
      $display("FAIL t3_total count=%0d cycles=%0d want 2/24", match_count, n);
    end
  endtask

  task automatic test_cfg_ignored();
    int h, n;
    load_bits(7, 256'b1010101);
    run_frame("t4", 8'b0000_1010, 4'd4, 8'd7, 100, 1'b1, -1, h, n);
    checks++;
    if (match_count !== 8'd2) begin
      failures++;
      $display("FAIL t4_total count=%0d want 2", match_count);
    end
    run_frame("t4_frame0", 8'hFF, 4'd1, 8'd0, 100, 1'b0, -1, h, n);
    checks++;
    if (match_count !== 8'd0 || n != 0) begin
      failures++;
      $display("FAIL t4_frame0 count=%0d loop=%0d want 0/0", match_count, n);
    end
  endtask

  task automatic test_saturation();
    int h, n;
    for (int i = 0; i < 10; i++) stim_bits[i] = 1'b1;
    run_frame("t5", 8'b0000_0001, 4'd1, 8'd10, 100, 1'b0, -1, h, n);
    checks++;
    if (s_match_count !== 3'd7 || s_overflow !== 1'b1 || match_count !== 8'd10) begin
      failures++;
      $display("FAIL t5_sat small=%0d ovf=%b big=%0d want 7/1/10", s_match_count, s_overflow, match_count);
    end
    for (int i = 0; i < 3; i++) stim_bits[i] = 1'b0;
    run_frame("t5_clear", 8'b0000_0001, 4'd1, 8'd3, 100, 1'b0, -1, h, n);
    checks++;
    if (s_match_count !== 3'd0 || s_overflow !== 1'b0) begin
      failures++;
      $display("FAIL t5_clear small=%0d ovf=%b want 0/0", s_match_count, s_overflow);
    end
  endtask

  task automatic test_reset_mid_run();
    int h, n;
    load_bits(12, 256'b110011001100);
    run_frame("t6_abort", 8'b0011_0011, 4'd6, 8'd12, 100, 1'b0, 5, h, n);
    run_frame("t6_rerun", 8'b0011_0011, 4'd6, 8'd12, 100, 1'b0, -1, h, n);
    checks++;
    if (match_count !== 8'd2) begin
      failures++;
      $display("FAIL t6_total count=%0d want 2", match_count);
    end
  endtask

  task automatic test_random();
    int h, n, mode, flen;
    logic [7:0] pat;
    logic [3:0] len;
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 3);
      flen = $urandom_range(0, 30);
      if (mode == 0) begin
        pat = 8'hFF;
        len = 4'($urandom_range(1, 3));
        for (int i = 0; i < flen; i++) stim_bits[i] = 1'b1;
      end else begin
        pat = 8'($urandom);
        len = 4'($urandom_range(0, 10));
        for (int i = 0; i < flen; i++) stim_bits[i] = 1'($urandom_range(0, 1));
      end
      run_frame("rand", pat, len, 8'(flen), $urandom_range(40, 100), bit'(mode == 1), -1, h, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; a = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_frame_len = '0;
    test_reset();
    test_pattern_0011();
    test_pattern_1010();
    test_gapped_valid();
    test_cfg_ignored();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
